// File: rtl/hap_pkg.sv
// Shared constants for the HAP compare sequencer: opcodes, FSM encoding, default widths.
package hap_pkg;

  localparam int unsigned DEF_DW = 3;
  localparam int unsigned DEF_AW = 3;
  localparam int unsigned OPW    = 5;

  localparam logic [OPW-1:0] OP_LT  = 5'b01011;
  localparam logic [OPW-1:0] OP_GT  = 5'b01100;
  localparam logic [OPW-1:0] OP_EQ  = 5'b01101;
  localparam logic [OPW-1:0] OP_GTE = 5'b01110;
  localparam logic [OPW-1:0] OP_LTE = 5'b01111;
  localparam logic [OPW-1:0] OP_NE  = 5'b10000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/cmp_core.sv
// Combinational unsigned compare evaluation; flags any opcode outside the compare group.
module cmp_core
  import hap_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic [OPW-1:0] opcode,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  output logic           result,
  output logic           legal
);

  always_comb begin
    result = 1'b0;
    legal  = 1'b1;
    case (opcode)
      OP_LT:   result = (a <  b);
      OP_GT:   result = (a >  b);
      OP_EQ:   result = (a == b);
      OP_GTE:  result = (a >= b);
      OP_LTE:  result = (a <= b);
      OP_NE:   result = (a != b);
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WRITE) executing one compare per handshake.
// Optional CMP_FLAG_EN adds a sticky cmp_flag output holding the last legal result.
module cmp_sequencer
  import hap_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ins_valid,
  output logic           ins_ready,
  input  logic [OPW-1:0] ins_opcode,
  input  logic [AW-1:0]  ins_rd,
  input  logic [AW-1:0]  ins_rs1,
  input  logic [AW-1:0]  ins_rs2,
  output logic [AW-1:0]  rf_raddr1,
  output logic [AW-1:0]  rf_raddr2,
  input  logic [DW-1:0]  rf_rdata1,
  input  logic [DW-1:0]  rf_rdata2,
  output logic           rf_we,
  output logic [AW-1:0]  rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic           done,
  output logic           err
`ifdef CMP_FLAG_EN
  ,
  output logic           cmp_flag
`endif
);

  logic [1:0]     state_q,  state_d;
  logic           ready_q,  ready_d;
  logic [OPW-1:0] op_q,     op_d;
  logic [AW-1:0]  rd_q,     rd_d;
  logic [AW-1:0]  raddr1_q, raddr1_d;
  logic [AW-1:0]  raddr2_q, raddr2_d;
  logic [DW-1:0]  opa_q,    opa_d;
  logic [DW-1:0]  opb_q,    opb_d;
  logic           we_q,     we_d;
  logic [AW-1:0]  waddr_q,  waddr_d;
  logic [DW-1:0]  wdata_q,  wdata_d;
  logic           done_q,   done_d;
  logic           err_q,    err_d;
`ifdef CMP_FLAG_EN
  logic           flag_q,   flag_d;
`endif

  logic core_result_c;
  logic core_legal_c;

  cmp_core #(.DW(DW)) u_core (
    .opcode (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .result (core_result_c),
    .legal  (core_legal_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      op_q     <= '0;
      rd_q     <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CMP_FLAG_EN
      flag_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef CMP_FLAG_EN
      flag_q   <= flag_d;
`endif
    end
  end

  // Next state; write-back outputs are loaded on the EXEC->WRITE edge so they are registered in WRITE
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    op_d     = op_q;
    rd_d     = rd_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef CMP_FLAG_EN
    flag_d   = flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ins_valid && ready_q) begin
          op_d     = ins_opcode;
          rd_d     = ins_rd;
          raddr1_d = ins_rs1;
          raddr2_d = ins_rs2;
          ready_d  = 1'b0;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        opa_d   = rf_rdata1;
        opb_d   = rf_rdata2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        done_d  = 1'b1;
        err_d   = ~core_legal_c;
        we_d    = core_legal_c;
        if (core_legal_c) begin
          waddr_d = rd_q;
          wdata_d = {{(DW-1){1'b0}}, core_result_c};
`ifdef CMP_FLAG_EN
          flag_d  = core_result_c;
`endif
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ins_ready = ready_q;
  assign rf_raddr1 = raddr1_q;
  assign rf_raddr2 = raddr2_q;
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef CMP_FLAG_EN
  assign cmp_flag  = flag_q;
`endif

endmodule

// File: tb/tb_cmp_sequencer.sv
// Directed bench for cmp_sequencer with a behavioural 8x3 register file; checks cmp_flag when CMP_FLAG_EN is defined.
module tb_cmp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ins_valid;
  logic       ins_ready;
  logic [4:0] ins_opcode;
  logic [2:0] ins_rd, ins_rs1, ins_rs2;
  logic [2:0] rf_raddr1, rf_raddr2;
  logic [2:0] rf_rdata1, rf_rdata2;
  logic       rf_we;
  logic [2:0] rf_waddr, rf_wdata;
  logic       done, err;
`ifdef CMP_FLAG_EN
  logic       cmp_flag;
`endif

  logic [2:0] rf [8];
  logic       pre_we;
  logic [2:0] pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmp_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_opcode (ins_opcode),
    .ins_rd     (ins_rd),
    .ins_rs1    (ins_rs1),
    .ins_rs2    (ins_rs2),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .done       (done),
    .err        (err)
`ifdef CMP_FLAG_EN
    ,
    .cmp_flag   (cmp_flag)
`endif
  );

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [2:0] a, input logic [2:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one instruction and check every cycle up to the next accept slot (N+4).
  task automatic run(input string tag, input bit b2b, input logic [4:0] op,
                     input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic exp_we, input logic [2:0] exp_wd, input logic exp_err,
                     input logic exp_flag);
    if (!b2b) @(negedge clk);
    chk({tag, "/accept_rdy"}, 8'(ins_ready), 8'd1);
    ins_valid = 1'b1; ins_opcode = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2;
    @(posedge clk); #1;
    ins_valid  = 1'b0;
    ins_opcode = 5'($urandom); ins_rd = 3'($urandom);
    ins_rs1    = 3'($urandom); ins_rs2 = 3'($urandom);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk({tag, "/busy_rdy"}, 8'(ins_ready), 8'd0);
      chk({tag, "/busy_we"},  8'(rf_we),     8'd0);
      chk({tag, "/busy_done"}, 8'(done),     8'd0);
    end
    @(negedge clk);
    chk({tag, "/we"},   8'(rf_we), 8'(exp_we));
    chk({tag, "/done"}, 8'(done),  8'd1);
    chk({tag, "/err"},  8'(err),   8'(exp_err));
    chk({tag, "/rdy3"}, 8'(ins_ready), 8'd0);
    if (exp_we) begin
      chk({tag, "/waddr"}, 8'(rf_waddr), 8'(rd));
      chk({tag, "/wdata"}, 8'(rf_wdata), 8'(exp_wd));
    end
`ifdef CMP_FLAG_EN
    chk({tag, "/flag"}, 8'(cmp_flag), 8'(exp_flag));
`else
    if (exp_flag === 1'bx) chk({tag, "/flag_arg"}, 8'(exp_flag), 8'd0);
`endif
    @(negedge clk);
    chk({tag, "/rdy4"},  8'(ins_ready), 8'd1);
    chk({tag, "/we4"},   8'(rf_we),     8'd0);
    chk({tag, "/done4"}, 8'(done),      8'd0);
    chk({tag, "/err4"},  8'(err),       8'd0);
  endtask

  initial begin
    rst = 1'b1; ins_valid = 1'b0; ins_opcode = '0; ins_rd = '0; ins_rs1 = '0; ins_rs2 = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_raddr1", 8'(rf_raddr1), 8'd0);
    chk("rst_waddr",  8'(rf_waddr),  8'd0);
    chk("rst_wdata",  8'(rf_wdata),  8'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_rdy",  8'(ins_ready), 8'd1);
      chk("idle_we",   8'(rf_we),     8'd0);
      chk("idle_done", 8'(done),      8'd0);
      chk("idle_err",  8'(err),       8'd0);
`ifdef CMP_FLAG_EN
      chk("idle_flag", 8'(cmp_flag), 8'd0);
`endif
    end

    for (int i = 0; i < 8; i++) poke(3'(i), 3'd0);
    poke(3'd1, 3'd2); poke(3'd2, 3'd5); poke(3'd4, 3'd6); poke(3'd5, 3'd6);

    run("lt_basic", 1'b0, 5'b01011, 3'd3, 3'd1, 3'd2, 1'b1, 3'd1, 1'b0, 1'b1);
    chk("lt_basic_r3", 8'(rf[3]), 8'd1);
    run("gt_rev",   1'b0, 5'b01100, 3'd7, 3'd2, 3'd1, 1'b1, 3'd1, 1'b0, 1'b1);
    run("lt_false", 1'b0, 5'b01011, 3'd7, 3'd4, 3'd1, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("lt_false_r7", 8'(rf[7]), 8'd0);

    run("eq_lt",  1'b0, 5'b01011, 3'd6, 3'd4, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    run("eq_gt",  1'b1, 5'b01100, 3'd6, 3'd4, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    run("eq_eq",  1'b1, 5'b01101, 3'd6, 3'd4, 3'd5, 1'b1, 3'd1, 1'b0, 1'b1);
    run("eq_gte", 1'b1, 5'b01110, 3'd6, 3'd4, 3'd5, 1'b1, 3'd1, 1'b0, 1'b1);
    run("eq_lte", 1'b1, 5'b01111, 3'd6, 3'd4, 3'd5, 1'b1, 3'd1, 1'b0, 1'b1);
    run("eq_ne",  1'b1, 5'b10000, 3'd6, 3'd4, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("eq_ne_r6", 8'(rf[6]), 8'd0);

    poke(3'd1, 3'd7); poke(3'd2, 3'd0);
    run("alias_gt", 1'b0, 5'b01100, 3'd1, 3'd1, 3'd2, 1'b1, 3'd1, 1'b0, 1'b1);
    run("alias_eq", 1'b1, 5'b01101, 3'd2, 3'd1, 3'd1, 1'b1, 3'd1, 1'b0, 1'b1);
    chk("alias_r1", 8'(rf[1]), 8'd1);
    chk("alias_r2", 8'(rf[2]), 8'd1);

    run("ill_00000", 1'b0, 5'b00000, 3'd3, 3'd4, 3'd1, 1'b0, 3'd0, 1'b1, 1'b1);
    run("ill_10001", 1'b1, 5'b10001, 3'd3, 3'd4, 3'd1, 1'b0, 3'd0, 1'b1, 1'b1);
    run("ill_01010", 1'b1, 5'b01010, 3'd3, 3'd4, 3'd1, 1'b0, 3'd0, 1'b1, 1'b1);
    chk("ill_r3", 8'(rf[3]), 8'd1);

    // GT r4(6) > r1(1) would write 1 to r0; reset lands in EXEC and must suppress it.
    @(negedge clk);
    ins_valid = 1'b1; ins_opcode = 5'b01100; ins_rd = 3'd0; ins_rs1 = 3'd4; ins_rs2 = 3'd1;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_in_exec_rdy", 8'(ins_ready), 8'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy",  8'(ins_ready), 8'd1);
    chk("mid_rst_we",   8'(rf_we),     8'd0);
    chk("mid_rst_done", 8'(done),      8'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mid_hold_we",   8'(rf_we), 8'd0);
      chk("mid_hold_done", 8'(done),  8'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_post_rdy",  8'(ins_ready), 8'd1);
      chk("mid_post_we",   8'(rf_we),     8'd0);
      chk("mid_post_done", 8'(done),      8'd0);
`ifdef CMP_FLAG_EN
      chk("mid_post_flag", 8'(cmp_flag), 8'd0);
`endif
    end
    chk("mid_r0", 8'(rf[0]), 8'd0);

    run("post_rst_lt", 1'b0, 5'b01011, 3'd3, 3'd1, 3'd4, 1'b1, 3'd1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
